// File: rtl/subleq_core_p.sv
// subleq_core_p: multi-cycle SUBLEQ core, one memory access per state over a req/ack port.
// Optional SUBLEQ_HALT_EN: a taken branch to an address with its MSB set parks the core in HALT until reset.
module subleq_core_p #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted
);

    localparam int                WB  = DATA_W / 8;
    localparam logic [ADDR_W-1:0] WB1 = ADDR_W'(WB);
    localparam logic [ADDR_W-1:0] WB2 = ADDR_W'(2 * WB);
    localparam logic [ADDR_W-1:0] WB3 = ADDR_W'(3 * WB);

`ifdef SUBLEQ_HALT_EN
    typedef enum logic [2:0] {FA, FB, FC, RA, RB, WR, HALT} state_t;
`else
    typedef enum logic [2:0] {FA, FB, FC, RA, RB, WR} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [ADDR_W-1:0] b_q, b_d;
    logic [ADDR_W-1:0] c_q, c_d;
    logic [DATA_W-1:0] va_q, va_d;
    logic [DATA_W-1:0] vb_q, vb_d;
    logic              req_q, req_d;

    logic [DATA_W-1:0] diff;
    logic              take;
    logic              go_halt;
    logic              in_halt;

    assign diff = vb_q - va_q;
    // Signed (VB-VA) <= 0: negative or exactly zero.
    assign take = diff[DATA_W-1] | (diff == '0);

`ifdef SUBLEQ_HALT_EN
    assign in_halt = (state_q == HALT);
`else
    assign in_halt = 1'b0;
`endif

    assign halted    = in_halt;
    assign mem_req   = req_q;
    assign mem_we    = (state_q == WR);
    assign mem_wdata = (state_q == WR) ? diff : '0;

    // Address depends only on registered state, so it holds while a request waits.
    always_comb begin
        mem_addr = pc_q;
        case (state_q)
            FB:      mem_addr = pc_q + WB1;
            FC:      mem_addr = pc_q + WB2;
            RA:      mem_addr = a_q;
            RB:      mem_addr = b_q;
            WR:      mem_addr = b_q;
            default: mem_addr = pc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        va_d    = va_q;
        vb_d    = vb_q;
        req_d   = req_q;
        go_halt = 1'b0;
        if (req_q) begin
            if (mem_ack) begin
                case (state_q)
                    FA: begin
                        a_d     = mem_rdata[ADDR_W-1:0];
                        state_d = FB;
                    end
                    FB: begin
                        b_d     = mem_rdata[ADDR_W-1:0];
                        state_d = FC;
                    end
                    FC: begin
                        c_d     = mem_rdata[ADDR_W-1:0];
                        state_d = RA;
                    end
                    RA: begin
                        va_d    = mem_rdata;
                        state_d = RB;
                    end
                    RB: begin
                        vb_d    = mem_rdata;
                        state_d = WR;
                    end
                    WR: begin
                        state_d = FA;
                        if (take) begin
`ifdef SUBLEQ_HALT_EN
                            if (c_q[ADDR_W-1]) begin
                                state_d = HALT;
                                go_halt = 1'b1;
                            end else begin
                                pc_d = c_q;
                            end
`else
                            pc_d = c_q;
`endif
                        end else begin
                            pc_d = pc_q + WB3;
                        end
                    end
                    default: state_d = FA;
                endcase
                req_d = cpu_en & ~go_halt;
            end
        end else if (cpu_en && !in_halt) begin
            req_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FA;
            pc_q    <= RESET_PC;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            va_q    <= '0;
            vb_q    <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            va_q    <= va_d;
            vb_q    <= vb_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: tb/tb_subleq_core_p.sv
// Bench for subleq_core_p (DATA_W=32, ADDR_W=16): an instruction-level model predicts every memory
// access into a queue; the memory responder pops and compares as the core issues them.
module tb_subleq_core_p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_en;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        halted;

    subleq_core_p #(.DATA_W(32), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_en    (cpu_en),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        fa;
    } acc_t;

    acc_t        exp_q[$];
    logic [31:0] mem     [16384];
    logic [31:0] ref_mem [16384];
    logic [15:0] m_pc;
    bit          m_halt;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [31:0] rd(input logic [15:0] ad);
        return ref_mem[ad[15:2]];
    endfunction

    // Instruction-level reference: predicts the six accesses of each instruction.
    task automatic gen(input int n);
        logic [31:0] a, b, c, va, vb, d;
        logic [15:0] p1, p2;
        for (int i = 0; i < n; i++) begin
            p1 = m_pc + 16'd4;
            p2 = m_pc + 16'd8;
            a  = rd(m_pc);
            b  = rd(p1);
            c  = rd(p2);
            va = rd(a[15:0]);
            vb = rd(b[15:0]);
            d  = vb - va;
            exp_q.push_back('{addr: m_pc,     we: 1'b0, wdata: 32'h0, fa: 1'b1});
            exp_q.push_back('{addr: p1,       we: 1'b0, wdata: 32'h0, fa: 1'b0});
            exp_q.push_back('{addr: p2,       we: 1'b0, wdata: 32'h0, fa: 1'b0});
            exp_q.push_back('{addr: a[15:0],  we: 1'b0, wdata: 32'h0, fa: 1'b0});
            exp_q.push_back('{addr: b[15:0],  we: 1'b0, wdata: 32'h0, fa: 1'b0});
            exp_q.push_back('{addr: b[15:0],  we: 1'b1, wdata: d,     fa: 1'b0});
            ref_mem[b[15:2]] = d;
            if ($signed(d) <= 0) begin
`ifdef SUBLEQ_HALT_EN
                if (c[15]) m_halt = 1'b1;
                else       m_pc = c[15:0];
`else
                m_pc = c[15:0];
`endif
            end else begin
                m_pc = m_pc + 16'd12;
            end
        end
    endtask

    // Memory responder: ack after dly waiting cycles; optional cpu_en toggling while waiting.
    task automatic run(input int n, input int dly, input bit tog, input bit tput);
        acc_t        e;
        int          cyc, wt, last_fa;
        bit          held, first;
        logic [48:0] hold;
        gen(n);
        cpu_en  = 1'b1;
        cyc     = 0;
        wt      = 0;
        held    = 1'b0;
        first   = 1'b1;
        last_fa = -1;
        while (exp_q.size() > 0 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            mem_ack = 1'b0;
            if (mem_req) begin
                if (tput && first) check_eq("first_req_latency", cyc, 1);
                first = 1'b0;
                if (held) check_eq("req_hold", {mem_addr, mem_we, mem_wdata}, hold);
                else begin
                    hold = {mem_addr, mem_we, mem_wdata};
                    held = 1'b1;
                end
                if (wt >= dly) begin
                    e = exp_q.pop_front();
                    check_eq("addr", mem_addr, e.addr);
                    check_eq("we", mem_we, e.we);
                    if (e.we) begin
                        check_eq("wdata", mem_wdata, e.wdata);
                        mem[mem_addr[15:2]] = mem_wdata;
                    end else begin
                        mem_rdata = mem[mem_addr[15:2]];
                    end
                    if (tput && e.fa) begin
                        if (last_fa >= 0) check_eq("cycles_per_instr", cyc - last_fa, 6);
                        last_fa = cyc;
                    end
                    mem_ack = 1'b1;
                    wt      = 0;
                    held    = 1'b0;
                    cpu_en  = (exp_q.size() > 0);
                end else begin
                    wt++;
                    if (tog) cpu_en = ~cpu_en;
                end
            end else begin
                if (held) check_eq("req_dropped", mem_req, 1'b1);
                cpu_en = (exp_q.size() > 0);
            end
        end
        if (exp_q.size() > 0) begin
            check_eq("timeout_pending", exp_q.size(), 0);
            exp_q.delete();
        end
        @(negedge clk);
        mem_ack = 1'b0;
        cpu_en  = 1'b0;
    endtask

    task automatic restart();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_req", mem_req, 1'b0);
        check_eq("rst_we", mem_we, 1'b0);
        check_eq("rst_addr", mem_addr, 16'h0000);
        check_eq("rst_wdata", mem_wdata, 32'h0);
        check_eq("rst_halted", halted, 1'b0);
        cpu_en  = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Stray acks and idle cycles must not start anything.
        mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_eq("idle_req", mem_req, 1'b0);
        end
        mem_ack = 1'b0;
        m_pc    = 16'h0000;
        m_halt  = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    endtask

    initial begin
        rst_n     = 1'b1;
        cpu_en    = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;

        // Non-branching instruction, then one fetched from 0x0C.
        clear_mem();
        mem[0] = 32'h10; mem[1] = 32'h14; mem[2] = 32'h20;
        mem[4] = 32'd3;  mem[5] = 32'd5;
        restart();
        ref_mem = mem;
        run(2, 0, 1'b0, 1'b1);

        // Zero result branches to 0x20; next instruction does not branch.
        clear_mem();
        mem[0] = 32'h10; mem[1] = 32'h14; mem[2] = 32'h20;
        mem[4] = 32'd5;  mem[5] = 32'd5;
        mem[8] = 32'h30; mem[9] = 32'h34; mem[10] = 32'h40;
        mem[12] = 32'd1; mem[13] = 32'd9;
        restart();
        ref_mem = mem;
        run(2, 0, 1'b0, 1'b1);

        // Negative result with slow memory and cpu_en toggling.
        clear_mem();
        mem[0] = 32'h10; mem[1] = 32'h14; mem[2] = 32'h20;
        mem[4] = 32'd7;  mem[5] = 32'd5;
        restart();
        ref_mem = mem;
        run(1, 3, 1'b1, 1'b0);

        // Branch to 0xFFF8, wrap of pc to 0x0004, then one more.
        clear_mem();
        mem[0] = 32'h10; mem[1] = 32'h14; mem[2] = 32'hFFF8;
        mem[4] = 32'd9;  mem[5] = 32'd1;
        mem[16'h3FFE] = 32'h18; mem[16'h3FFF] = 32'h1C;
        mem[6] = 32'd1;  mem[7] = 32'd4;
        restart();
        ref_mem = mem;
        run(3, 2, 1'b1, 1'b0);

        // Reset asserted while the write request is outstanding.
        clear_mem();
        mem[0] = 32'h10; mem[1] = 32'h14; mem[2] = 32'h8000;
        mem[4] = 32'd5;  mem[5] = 32'd5;
        mem[16'h2000] = 32'h70; mem[16'h2001] = 32'h74; mem[16'h2002] = 32'h0;
        mem[16'h1C] = 32'd0; mem[16'h1D] = 32'd1;
        restart();
        cpu_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && mem_we) break;
            if (mem_req) begin
                mem_rdata = mem[mem_addr[15:2]];
                mem_ack   = 1'b1;
            end
        end
        check_eq("reached_write", {mem_req, mem_we}, 2'b11);
        restart();
        ref_mem = mem;
        run(1, 0, 1'b0, 1'b1);
`ifdef SUBLEQ_HALT_EN
        check_eq("halted_set", halted, 1'b1);
        cpu_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("halt_no_req", mem_req, 1'b0);
        end
        cpu_en = 1'b0;
`else
        check_eq("halted_low", halted, 1'b0);
        run(1, 0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
